// File: rtl/ikaopll_dac_pkg.sv
// ikaopll_dac_pkg: shared sample decode, group-select codes, FSM states and accumulator sizing
// for the mixing accumulation DAC.
package ikaopll_dac_pkg;

    localparam logic [1:0] GRP_NONE = 2'd0;
    localparam logic [1:0] GRP_MO   = 2'd1;
    localparam logic [1:0] GRP_RO   = 2'd2;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    function automatic int acc_width(input int sample_w, input int vol_w, input int slots);
        return sample_w + vol_w + $clog2(slots);
    endfunction

    // Sign+magnitude to two's complement: a negative sample inverts its magnitude, giving -mag-1
    function automatic logic [31:0] decode_sample(input logic [31:0] s, input int w);
        return s[w-1] ? s ^ ((32'd1 << (w - 1)) - 32'd1) : s;
    endfunction

endpackage

// File: rtl/ikaopll_dac_narrow.sv
// ikaopll_dac_narrow: scales the frame sum by 2^SHIFT and narrows it to OUT_W bits.
// IKAOPLL_DAC_MIXACC_SAT_EN selects saturation with a clip flag; otherwise the result wraps.
module ikaopll_dac_narrow #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    localparam int SW = IN_W + SHIFT;

    logic signed [SW-1:0] sh;

    assign sh = SW'(din) <<< SHIFT;

`ifdef IKAOPLL_DAC_MIXACC_SAT_EN
    logic fits;

    // In range exactly when every bit above the output sign bit matches it
    assign fits = &sh[SW-1:OUT_W-1] | ~|sh[SW-1:OUT_W-1];
    assign clip = ~fits;
    assign dout = fits ? sh[OUT_W-1:0] : {sh[SW-1], {(OUT_W-1){~sh[SW-1]}}};
`else
    logic unused_hi;

    assign unused_hi = ^sh[SW-1:OUT_W];
    assign clip      = 1'b0;
    assign dout      = sh[OUT_W-1:0];
`endif

endmodule

// File: rtl/ikaopll_dac_mixacc.sv
// ikaopll_dac_mixacc: per-slot melody/rhythm volume mix summed over a slot frame, strobed once per frame.
// Define IKAOPLL_DAC_MIXACC_SAT_EN to saturate the frame result instead of wrapping it.
module ikaopll_dac_mixacc
    import ikaopll_dac_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 9,
    parameter int NUM_SLOTS    = 18,
    parameter int VOL_WIDTH    = 5,
    parameter int OUT_WIDTH    = 16,
    parameter int OUT_SHIFT    = 4
) (
    input  logic                        i_EMUCLK,
    input  logic                        i_RST,
    input  logic                        i_phi1_NCEN_n,
    input  logic                        i_CYCLE_00,
    input  logic [SAMPLE_WIDTH-1:0]     i_DAC_OPDATA,
    input  logic                        i_MO_CTRL,
    input  logic                        i_RO_CTRL,
    input  logic                        i_RHYTHM_EN,
    input  logic signed [VOL_WIDTH-1:0] i_MOVOL,
    input  logic signed [VOL_WIDTH-1:0] i_ROVOL,
    output logic signed [OUT_WIDTH-1:0] o_ACC,
    output logic                        o_ACC_STRB,
    output logic                        o_ACC_CLIP,
    output logic                        o_SYNC_ERR
);

    localparam int PROD_W = SAMPLE_WIDTH + VOL_WIDTH;
    localparam int ACC_W  = acc_width(SAMPLE_WIDTH, VOL_WIDTH, NUM_SLOTS);
    localparam int CNT_W  = $clog2(NUM_SLOTS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLOTS - 1);

    state_t                       state, state_nxt;
    logic                         en;
    logic signed [SAMPLE_WIDTH-1:0] s1_val;
    logic [1:0]                   s1_grp;
    logic                         s1_tag, s2_tag;
    logic signed [VOL_WIDTH-1:0]  vol;
    logic signed [PROD_W-1:0]     s2_prod;
    logic signed [ACC_W-1:0]      acc, acc_nxt;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic                         emit, err_set, clip;
    logic signed [OUT_WIDTH-1:0]  acc_out;

    assign en  = ~i_phi1_NCEN_n;
    assign vol = s1_grp == GRP_RO ? i_ROVOL : s1_grp == GRP_MO ? i_MOVOL : '0;

    // S3 frame control: IDLE only waits for the first tagged product to seed the accumulator
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        err_set   = 1'b0;
        if (state == ST_IDLE) begin
            state_nxt = s2_tag ? ST_RUN : ST_IDLE;
            acc_nxt   = s2_tag ? ACC_W'(s2_prod) : acc;
        end else if (s2_tag) begin
            emit    = 1'b1;
            err_set = cnt != LAST;
            acc_nxt = ACC_W'(s2_prod);
            cnt_nxt = '0;
        end else begin
            err_set = cnt == LAST;
            acc_nxt = acc + ACC_W'(s2_prod);
            cnt_nxt = cnt == LAST ? '0 : cnt + CNT_W'(1);
        end
    end

    ikaopll_dac_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_WIDTH),
        .SHIFT (OUT_SHIFT)
    ) u_narrow (
        .din  (acc),
        .dout (acc_out),
        .clip (clip)
    );

    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            state      <= ST_IDLE;
            s1_val     <= '0;
            s1_grp     <= GRP_NONE;
            s1_tag     <= 1'b0;
            s2_prod    <= '0;
            s2_tag     <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            o_ACC      <= '0;
            o_ACC_STRB <= 1'b0;
            o_ACC_CLIP <= 1'b0;
            o_SYNC_ERR <= 1'b0;
        end else begin
            o_ACC_STRB <= en & emit;
            if (en) begin
                s1_val     <= SAMPLE_WIDTH'(decode_sample(32'(i_DAC_OPDATA), SAMPLE_WIDTH));
                s1_grp     <= (i_RO_CTRL & i_RHYTHM_EN) ? GRP_RO : i_MO_CTRL ? GRP_MO : GRP_NONE;
                s1_tag     <= i_CYCLE_00;
                s2_prod    <= PROD_W'(s1_val) * PROD_W'(vol);
                s2_tag     <= s1_tag;
                state      <= state_nxt;
                acc        <= acc_nxt;
                cnt        <= cnt_nxt;
                o_SYNC_ERR <= o_SYNC_ERR | err_set;
                if (emit) begin
                    o_ACC      <= acc_out;
                    o_ACC_CLIP <= clip;
                end
            end
        end
    end

endmodule

// File: tb/tb_ikaopll_dac_mixacc.sv
// tb_ikaopll_dac_mixacc: scenario tasks driving slot frames, checked against an arithmetic frame-sum model.
module tb_ikaopll_dac_mixacc;

    logic clk = 1'b0;
    logic rst, ncen, cyc, mo, ro, rh;
    logic [8:0] opdata;
    logic signed [4:0] movol, rovol;
    logic signed [15:0] d_acc;
    logic d_strb, d_clip, d_serr;

    int n_cmp = 0;
    int n_bad = 0;
    int nstep = 0;
    int sq_t[$];
    logic signed [15:0] sq_v[$];
    logic sq_c[$];
    logic [8:0] fd[32];
    bit fmo[32];
    bit fro[32];

    always #5 clk = ~clk;

    ikaopll_dac_mixacc dut (
        .i_EMUCLK      (clk),
        .i_RST         (rst),
        .i_phi1_NCEN_n (ncen),
        .i_CYCLE_00    (cyc),
        .i_DAC_OPDATA  (opdata),
        .i_MO_CTRL     (mo),
        .i_RO_CTRL     (ro),
        .i_RHYTHM_EN   (rh),
        .i_MOVOL       (movol),
        .i_ROVOL       (rovol),
        .o_ACC         (d_acc),
        .o_ACC_STRB    (d_strb),
        .o_ACC_CLIP    (d_clip),
        .o_SYNC_ERR    (d_serr)
    );

    function automatic int contrib(input logic [8:0] d, input bit m, input bit r);
        int v;
        v = d[8] ? -int'(d[7:0]) - 1 : int'(d[7:0]);
        return (r && rh) ? v * int'(rovol) : m ? v * int'(movol) : 0;
    endfunction

    function automatic int fsum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += contrib(fd[i], fmo[i], fro[i]);
        return s;
    endfunction

    function automatic logic signed [15:0] nar_v(input int s);
        int v;
        v = s * 16;
`ifdef IKAOPLL_DAC_MIXACC_SAT_EN
        return v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : 16'(v);
`else
        return 16'(v);
`endif
    endfunction

    function automatic logic nar_c(input int s);
`ifdef IKAOPLL_DAC_MIXACC_SAT_EN
        return (s * 16 > 32767) || (s * 16 < -32768);
`else
        return s != s;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (d_strb === 1'b1) begin
            sq_t.push_back(nstep);
            sq_v.push_back(d_acc);
            sq_c.push_back(d_clip);
        end
        nstep++;
    endtask

    task automatic do_reset();
        rst = 1'b1; ncen = 1'b0; cyc = 1'b0; mo = 1'b0; ro = 1'b0; opdata = '0;
        step();
        step();
        rst = 1'b0;
        sq_t.delete(); sq_v.delete(); sq_c.delete();
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 32; i++) begin
            fd[i]  = rnd ? 9'($urandom) : 9'd0;
            fmo[i] = rnd ? 1'($urandom) : 1'b0;
            fro[i] = rnd ? 1'($urandom) : 1'b0;
        end
    endtask

    task automatic play_slots(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            cyc = (i == 0); opdata = fd[i]; mo = fmo[i]; ro = fro[i]; ncen = 1'b0;
            step();
        end
        cyc = 1'b0;
    endtask

    task automatic play(input int n, output int t);
        t = nstep;
        play_slots(0, n);
    endtask

    task automatic rand_vols();
        movol = 5'($urandom); rovol = 5'($urandom); rh = 1'($urandom);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (d_acc !== 16'sd0) begin n_bad++; $display("FAIL reset_acc: got %0d want 0", d_acc); end
        n_cmp++; if (d_strb !== 1'b0) begin n_bad++; $display("FAIL reset_strb: got %b want 0", d_strb); end
        n_cmp++; if (d_clip !== 1'b0) begin n_bad++; $display("FAIL reset_clip: got %b want 0", d_clip); end
        n_cmp++; if (d_serr !== 1'b0) begin n_bad++; $display("FAIL reset_serr: got %b want 0", d_serr); end
    endtask

    task automatic test_first_frame();
        int ta, tb, s;
        do_reset(); rand_vols();
        for (int i = 0; i < 5; i++) begin
            opdata = 9'($urandom); mo = 1'b1; ro = 1'b1; cyc = 1'b0;
            step();
        end
        fill(1); s = fsum(18); play(18, ta);
        n_cmp++; if (sq_t.size() !== 0) begin n_bad++; $display("FAIL first_none: got %0d strobes want 0", sq_t.size()); end
        fill(0); play(18, tb);
        n_cmp++;
        if (sq_t.size() !== 1) begin n_bad++; $display("FAIL first_count: got %0d want 1", sq_t.size()); end
        else begin
            n_cmp++; if (sq_t[0] !== tb + 2) begin n_bad++; $display("FAIL first_time: got %0d want %0d", sq_t[0], tb + 2); end
            n_cmp++; if (sq_v[0] !== nar_v(s)) begin n_bad++; $display("FAIL first_value: got %0d want %0d", sq_v[0], nar_v(s)); end
        end
    endtask

    task automatic test_single_mo();
        int t0, t1, t2;
        do_reset(); movol = 5'sd1; rovol = 5'sd0; rh = 1'b0;
        fill(0); play(18, t0);
        fd[5] = 9'h010; fmo[5] = 1'b1; play(18, t1);
        fill(0); play(18, t2);
        n_cmp++;
        if (sq_t.size() !== 2) begin n_bad++; $display("FAIL mo_count: got %0d want 2", sq_t.size()); end
        else begin
            n_cmp++; if (sq_t[1] !== t2 + 2) begin n_bad++; $display("FAIL mo_time: got %0d want %0d", sq_t[1], t2 + 2); end
            n_cmp++; if (sq_v[1] !== 16'sd256) begin n_bad++; $display("FAIL mo_value: got %0d want 256", sq_v[1]); end
        end
    endtask

    task automatic test_negative_ro();
        int t0, t1, t2, t3;
        do_reset(); movol = 5'sd7; rovol = 5'sd2; rh = 1'b1;
        fill(0); play(18, t0);
        fd[3] = 9'h10F; fro[3] = 1'b1; play(18, t1);
        rh = 1'b0; play(18, t2);
        fill(0); play(18, t3);
        n_cmp++;
        if (sq_t.size() !== 3) begin n_bad++; $display("FAIL ro_count: got %0d want 3", sq_t.size()); end
        else begin
            n_cmp++; if (sq_v[1] !== -16'sd512) begin n_bad++; $display("FAIL ro_value: got %0d want -512", sq_v[1]); end
            n_cmp++; if (sq_v[2] !== 16'sd0) begin n_bad++; $display("FAIL ro_disabled: got %0d want 0", sq_v[2]); end
        end
    endtask

    task automatic test_overload();
        int t0, t1, t2;
        logic signed [15:0] ev;
        logic ec;
`ifdef IKAOPLL_DAC_MIXACC_SAT_EN
        ev = 16'sd32767; ec = 1'b1;
`else
        ev = -16'sd12512; ec = 1'b0;
`endif
        do_reset(); movol = 5'sd15; rovol = 5'sd0; rh = 1'b0;
        fill(0); play(18, t0);
        for (int i = 0; i < 18; i++) begin fd[i] = 9'h0FF; fmo[i] = 1'b1; end
        play(18, t1);
        fill(0); play(18, t2);
        n_cmp++;
        if (sq_t.size() !== 2) begin n_bad++; $display("FAIL ovl_count: got %0d want 2", sq_t.size()); end
        else begin
            n_cmp++; if (sq_v[1] !== ev) begin n_bad++; $display("FAIL ovl_value: got %0d want %0d", sq_v[1], ev); end
            n_cmp++; if (sq_c[1] !== ec) begin n_bad++; $display("FAIL ovl_clip: got %b want %b", sq_c[1], ec); end
        end
    endtask

    task automatic test_back_to_back();
        int ts[7];
        int sm[6];
        do_reset(); rand_vols();
        for (int k = 0; k < 6; k++) begin
            fill(1); sm[k] = fsum(18); play(18, ts[k]);
        end
        fill(0); play(3, ts[6]);
        n_cmp++;
        if (sq_t.size() !== 6) begin n_bad++; $display("FAIL b2b_count: got %0d want 6", sq_t.size()); end
        else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++; if (sq_t[k] !== ts[k+1] + 2) begin n_bad++; $display("FAIL b2b_time[%0d]: got %0d want %0d", k, sq_t[k], ts[k+1] + 2); end
                n_cmp++; if (sq_v[k] !== nar_v(sm[k])) begin n_bad++; $display("FAIL b2b_value[%0d]: got %0d want %0d", k, sq_v[k], nar_v(sm[k])); end
                n_cmp++; if (sq_c[k] !== nar_c(sm[k])) begin n_bad++; $display("FAIL b2b_clip[%0d]: got %b want %b", k, sq_c[k], nar_c(sm[k])); end
            end
        end
        n_cmp++; if (d_serr !== 1'b0) begin n_bad++; $display("FAIL b2b_serr: got %b want 0", d_serr); end
    endtask

    task automatic test_sync_short();
        int t0, ts, tz, s;
        do_reset(); rand_vols();
        fill(0); play(18, t0);
        fill(1); s = fsum(10); play(10, ts);
        n_cmp++; if (d_serr !== 1'b0) begin n_bad++; $display("FAIL short_serr_pre: got %b want 0", d_serr); end
        fill(0); play(18, tz);
        n_cmp++; if (d_serr !== 1'b1) begin n_bad++; $display("FAIL short_serr: got %b want 1", d_serr); end
        n_cmp++;
        if (sq_t.size() !== 2) begin n_bad++; $display("FAIL short_count: got %0d want 2", sq_t.size()); end
        else begin
            n_cmp++; if (sq_t[1] !== tz + 2) begin n_bad++; $display("FAIL short_time: got %0d want %0d", sq_t[1], tz + 2); end
            n_cmp++; if (sq_v[1] !== nar_v(s)) begin n_bad++; $display("FAIL short_value: got %0d want %0d", sq_v[1], nar_v(s)); end
        end
    endtask

    task automatic test_sync_long();
        int t0, tl, tz, s;
        do_reset(); rand_vols();
        fill(0); play(18, t0);
        fill(1); s = fsum(25); play(25, tl);
        n_cmp++; if (d_serr !== 1'b1) begin n_bad++; $display("FAIL long_serr: got %b want 1", d_serr); end
        fill(0); play(18, tz);
        n_cmp++;
        if (sq_t.size() !== 2) begin n_bad++; $display("FAIL long_count: got %0d want 2", sq_t.size()); end
        else begin
            n_cmp++; if (sq_t[1] !== tz + 2) begin n_bad++; $display("FAIL long_time: got %0d want %0d", sq_t[1], tz + 2); end
            n_cmp++; if (sq_v[1] !== nar_v(s)) begin n_bad++; $display("FAIL long_value: got %0d want %0d", sq_v[1], nar_v(s)); end
        end
    endtask

    task automatic test_reset_midframe();
        int t0, ta, tb, tc, td, s;
        do_reset(); rand_vols();
        fill(0); play(18, t0);
        fill(1); play(18, ta);
        fill(1); play(7, tb);
        do_reset();
        n_cmp++; if (d_acc !== 16'sd0) begin n_bad++; $display("FAIL mid_acc: got %0d want 0", d_acc); end
        n_cmp++; if (d_strb !== 1'b0) begin n_bad++; $display("FAIL mid_strb: got %b want 0", d_strb); end
        n_cmp++; if (d_clip !== 1'b0) begin n_bad++; $display("FAIL mid_clip: got %b want 0", d_clip); end
        fill(1); s = fsum(18); play(18, tc);
        fill(0); play(18, td);
        n_cmp++;
        if (sq_t.size() !== 1) begin n_bad++; $display("FAIL mid_count: got %0d want 1", sq_t.size()); end
        else begin
            n_cmp++; if (sq_t[0] !== td + 2) begin n_bad++; $display("FAIL mid_time: got %0d want %0d", sq_t[0], td + 2); end
            n_cmp++; if (sq_v[0] !== nar_v(s)) begin n_bad++; $display("FAIL mid_value: got %0d want %0d", sq_v[0], nar_v(s)); end
        end
        n_cmp++; if (d_serr !== 1'b0) begin n_bad++; $display("FAIL mid_serr: got %b want 0", d_serr); end
    endtask

    task automatic test_stall();
        int t0, ta, tb, tc, sa, sb;
        do_reset(); rand_vols();
        fill(0); play(18, t0);
        fill(1); sa = fsum(18); play(18, ta);
        fill(1); sb = fsum(18); tb = nstep; play_slots(0, 3);
        ncen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc = 1'($urandom); opdata = 9'($urandom); mo = 1'($urandom); ro = 1'($urandom);
            step();
            if (i == 0) begin
                n_cmp++; if (d_strb !== 1'b0) begin n_bad++; $display("FAIL stall_strb: got %b want 0", d_strb); end
            end
        end
        n_cmp++; if (d_acc !== nar_v(sa)) begin n_bad++; $display("FAIL stall_hold: got %0d want %0d", d_acc, nar_v(sa)); end
        play_slots(3, 18);
        fill(0); play(3, tc);
        n_cmp++;
        if (sq_t.size() !== 3) begin n_bad++; $display("FAIL stall_count: got %0d want 3", sq_t.size()); end
        else begin
            n_cmp++; if (sq_t[1] !== tb + 2) begin n_bad++; $display("FAIL stall_time: got %0d want %0d", sq_t[1], tb + 2); end
            n_cmp++; if (sq_v[2] !== nar_v(sb)) begin n_bad++; $display("FAIL stall_value: got %0d want %0d", sq_v[2], nar_v(sb)); end
        end
        n_cmp++; if (d_serr !== 1'b0) begin n_bad++; $display("FAIL stall_serr: got %b want 0", d_serr); end
    endtask

    initial begin
        rst = 1'b1; ncen = 1'b0; cyc = 1'b0; mo = 1'b0; ro = 1'b0; rh = 1'b0;
        opdata = '0; movol = '0; rovol = '0;
        test_reset();
        test_first_frame();
        test_single_mo();
        test_negative_ro();
        test_overload();
        test_back_to_back();
        test_sync_short();
        test_sync_long();
        test_reset_midframe();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
